// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          clear_overflow;

  modport master (
    output in_valid, in_byte, out_ready, clear_overflow,
    input  in_ready, out_valid, out_byte, count, overflow, drop_count
  );

  modport slave (
    input  in_valid, in_byte, out_ready, clear_overflow,
    output in_ready, out_valid, out_byte, count, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver. Never stalls the
// serial side: bytes arriving while full are dropped and counted instead.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          overflow_next;
  logic [7:0]    drop_count_reg;
  logic [7:0]    drop_count_next;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  assign full   = (count_reg == FULL_COUNT);
  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    count_next = count_reg;
    if (accept && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !accept) begin
      count_next = count_reg - CW'(1);
    end
  end

  // A drop in the same cycle as a clear restarts the tally at one.
  always_comb begin
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;
    if (drop) begin
      overflow_next = 1'b1;
      if (bus.clear_overflow) begin
        drop_count_next = 8'd1;
      end else if (drop_count_reg != 8'hFF) begin
        drop_count_next = drop_count_reg + 8'd1;
      end
    end else if (bus.clear_overflow) begin
      overflow_next   = 1'b0;
      drop_count_next = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg      <= count_next;
      overflow_reg   <= overflow_next;
      drop_count_reg <= drop_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= bus.in_byte;
    end
  end

  assign bus.in_ready   = !reset;
  assign bus.out_valid  = (count_reg != '0);
  assign bus.out_byte   = bus.out_valid ? mem[rd_ptr_reg] : 8'h00;
  assign bus.count      = count_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.drop_count = drop_count_reg;

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_reg <= FULL_COUNT);

  a_ptr_gap: assert property (@(posedge clk) disable iff (reset)
    count_reg[PW-1:0] == PW'(wr_ptr_reg - rd_ptr_reg));

  a_drop_holds_wr: assert property (@(posedge clk) disable iff (reset)
    drop |=> $stable(wr_ptr_reg));

  a_drop_flags: assert property (@(posedge clk) disable iff (reset)
    drop |=> overflow_reg && (drop_count_reg != 8'd0));
endmodule
